// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 register-table sequencer: after power-up it walks the ROM table and
// issues each 16-bit-address/8-bit-data write to the SCCB master, with soft-reset settle and NACK retry.
module ov5640_cfg_ctrl #(
    parameter int REG_NUM   = 252,
    parameter int IDX_W     = 8,
    parameter int START_DLY = 20000,
    parameter int RST_DLY   = 50000,
    parameter int MAX_RETRY = 3
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             power_done,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [23:0]      tbl_data,
    output logic             wr_req,
    output logic [15:0]      wr_addr,
    output logic [7:0]       wr_data,
    input  logic             wr_ack,
    input  logic             wr_nack,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int MAX_DLY = (START_DLY > RST_DLY) ? START_DLY : RST_DLY;
    localparam int CNT_W   = $clog2(MAX_DLY + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_FETCH, S_REQ, S_DELAY, S_DONE, S_ERR
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] dly_cnt, dly_cnt_nx;
    logic [RTY_W-1:0] rty_cnt, rty_nx, rty_inc;
    logic [IDX_W-1:0] idx_nx;
    logic [15:0]      addr_nx;
    logic [7:0]       data_nx;
    logic             req_nx, done_nx, err_nx;
    logic             start_end, rst_end, last_entry, soft_rst, rty_limit, got_nack, got_ack;

    assign start_end  = (dly_cnt == CNT_W'(START_DLY - 1));
    assign rst_end    = (dly_cnt == CNT_W'(RST_DLY - 1));
    assign last_entry = (tbl_idx == IDX_W'(REG_NUM - 1));
    // The latched request, not the live table word, decides whether to settle.
    assign soft_rst   = (wr_addr == 16'h3008) && wr_data[7];
    assign rty_inc    = rty_cnt + 1'b1;
    assign rty_limit  = (rty_inc == RTY_W'(MAX_RETRY));
    // A simultaneous ack and nack counts as a nack.
    assign got_nack   = wr_nack;
    assign got_ack    = wr_ack && !wr_nack;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= S_IDLE;
            dly_cnt  <= '0;
            rty_cnt  <= '0;
            tbl_idx  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_req   <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            dly_cnt  <= dly_cnt_nx;
            rty_cnt  <= rty_nx;
            tbl_idx  <= idx_nx;
            wr_addr  <= addr_nx;
            wr_data  <= data_nx;
            wr_req   <= req_nx;
            cfg_done <= done_nx;
            cfg_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!power_done) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nx = S_WAIT;
                S_WAIT:  if (start_end) state_nx = S_FETCH;
                S_FETCH: state_nx = S_REQ;
                S_REQ: begin
                    if (got_nack)
                        state_nx = rty_limit ? S_ERR : S_FETCH;
                    else if (got_ack)
                        state_nx = soft_rst ? S_DELAY : (last_entry ? S_DONE : S_FETCH);
                end
                S_DELAY: if (rst_end) state_nx = last_entry ? S_DONE : S_FETCH;
                S_DONE:  state_nx = S_DONE;
                S_ERR:   state_nx = S_ERR;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Next values for every registered output and counter.
    always_comb begin
        dly_cnt_nx = dly_cnt;
        rty_nx     = rty_cnt;
        idx_nx     = tbl_idx;
        addr_nx    = wr_addr;
        data_nx    = wr_data;
        if (!power_done) begin
            dly_cnt_nx = '0;
            rty_nx     = '0;
            idx_nx     = '0;
            addr_nx    = '0;
            data_nx    = '0;
        end else begin
            case (state)
                S_WAIT: dly_cnt_nx = start_end ? '0 : dly_cnt + 1'b1;
                S_FETCH: begin
                    addr_nx = tbl_data[23:8];
                    data_nx = tbl_data[7:0];
                end
                S_REQ: begin
                    if (got_nack) begin
                        rty_nx = rty_inc;
                    end else if (got_ack) begin
                        rty_nx = '0;
                        if (soft_rst)        dly_cnt_nx = '0;
                        else if (!last_entry) idx_nx    = tbl_idx + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (rst_end) begin
                        dly_cnt_nx = '0;
                        if (!last_entry) idx_nx = tbl_idx + 1'b1;
                    end else begin
                        dly_cnt_nx = dly_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        req_nx  = (state_nx == S_REQ);
        done_nx = (state_nx == S_DONE);
        err_nx  = (state_nx == S_ERR);
    end

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Directed bench for ov5640_cfg_ctrl: 4-entry table, responder acks/nacks
// 5 cycles after each wr_req rise, per-scenario tasks with inline checks.
module tb_ov5640_cfg_ctrl;
    localparam int REG_NUM = 4, IDX_W = 8, START_DLY = 10, RST_DLY = 20, MAX_RETRY = 3;

    logic             sclk, s_rst_n, power_done;
    logic [IDX_W-1:0] tbl_idx;
    logic [23:0]      tbl_data;
    logic             wr_req, wr_ack, wr_nack, cfg_done, cfg_err;
    logic [15:0]      wr_addr;
    logic [7:0]       wr_data;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int log_edge[$], resp_edge[$];
    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];
    int nack_plan[$];   // 0 = ack, 1 = nack, 2 = ack+nack together
    int done_edge = -1, err_edge = -1;

    ov5640_cfg_ctrl #(.REG_NUM(REG_NUM), .IDX_W(IDX_W), .START_DLY(START_DLY),
                      .RST_DLY(RST_DLY), .MAX_RETRY(MAX_RETRY)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .power_done(power_done), .tbl_idx(tbl_idx),
        .tbl_data(tbl_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_nack(wr_nack), .cfg_done(cfg_done), .cfg_err(cfg_err));

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    always_comb begin
        case (tbl_idx)
            8'd0:    tbl_data = {16'h3008, 8'h82};
            8'd1:    tbl_data = {16'h3103, 8'h11};
            8'd2:    tbl_data = {16'h3017, 8'hFF};
            8'd3:    tbl_data = {16'h4300, 8'h61};
            default: tbl_data = 24'h0;
        endcase
    end

    // Write-master model: log each request, answer on the 5th edge after it rises.
    initial begin
        bit req_prev;
        int kind;
        req_prev = 1'b0;
        wr_ack = 1'b0;
        wr_nack = 1'b0;
        forever begin
            @(posedge sclk); #1;
            if (wr_req && !req_prev) begin
                log_edge.push_back(cyc);
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
                repeat (4) begin @(posedge sclk); #1; end
                kind = 0;
                if (nack_plan.size() > 0) kind = nack_plan.pop_front();
                wr_ack  = (kind != 1);
                wr_nack = (kind != 0);
                @(posedge sclk); #1;
                wr_ack = 1'b0;
                wr_nack = 1'b0;
                resp_edge.push_back(cyc);
            end
            req_prev = wr_req;
        end
    end

    initial begin
        bit dp, ep;
        dp = 1'b0;
        ep = 1'b0;
        forever begin
            @(posedge sclk); #1;
            if (cfg_done && !dp) done_edge = cyc;
            if (cfg_err && !ep)  err_edge = cyc;
            dp = cfg_done;
            ep = cfg_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge sclk); #1; end
    endtask

    task automatic wait_flag(input string what, input int budget);
        int t;
        t = 0;
        while (!((what == "done") ? cfg_done : cfg_err) && t < budget) begin
            tick(1);
            t++;
        end
        n_cmp++;
        if (t >= budget) begin
            n_bad++;
            $display("FAIL wait_%s: timeout after %0d cycles, flag=0 required 1", what, budget);
        end
    endtask

    task automatic restart(output int k);
        power_done = 1'b0;
        tick(3);
        log_edge.delete(); log_addr.delete(); log_data.delete(); resp_edge.delete();
        done_edge = -1;
        err_edge = -1;
        power_done = 1'b1;
        k = cyc + 1;
    endtask

    task automatic test_reset;
        s_rst_n = 1'b0;
        power_done = 1'b0;
        tick(3);
        s_rst_n = 1'b1;
        tick(50);
        n_cmp++; if (tbl_idx !== 8'd0)   begin n_bad++; $display("FAIL rst_idx: got %0d want 0", tbl_idx); end
        n_cmp++; if (wr_req !== 1'b0)    begin n_bad++; $display("FAIL rst_req: got %b want 0", wr_req); end
        n_cmp++; if (wr_addr !== 16'h0)  begin n_bad++; $display("FAIL rst_addr: got %h want 0000", wr_addr); end
        n_cmp++; if (wr_data !== 8'h0)   begin n_bad++; $display("FAIL rst_data: got %h want 00", wr_data); end
        n_cmp++; if (cfg_done !== 1'b0)  begin n_bad++; $display("FAIL rst_done: got %b want 0", cfg_done); end
        n_cmp++; if (cfg_err !== 1'b0)   begin n_bad++; $display("FAIL rst_err: got %b want 0", cfg_err); end
        n_cmp++; if (log_edge.size() != 0) begin n_bad++; $display("FAIL rst_noreq: got %0d writes want 0", log_edge.size()); end
    endtask

    task automatic test_first_req(output int k);
        int t;
        log_edge.delete(); log_addr.delete(); log_data.delete(); resp_edge.delete();
        power_done = 1'b1;
        k = cyc + 1;
        t = 0;
        while (log_edge.size() == 0 && t < 100) begin tick(1); t++; end
        n_cmp++; if (log_edge.size() == 0 || log_edge[0] != k + START_DLY + 1)
            begin n_bad++; $display("FAIL first_req_edge: got %0d want %0d", (log_edge.size() > 0) ? log_edge[0] : -1, k + START_DLY + 1); end
        n_cmp++; if (log_addr.size() == 0 || log_addr[0] !== 16'h3008)
            begin n_bad++; $display("FAIL first_req_addr: got %h want 3008", wr_addr); end
        n_cmp++; if (log_data.size() == 0 || log_data[0] !== 8'h82)
            begin n_bad++; $display("FAIL first_req_data: got %h want 82", wr_data); end
    endtask

    task automatic test_full_run;
        logic [15:0] ea[4];
        ea = '{16'h3008, 16'h3103, 16'h3017, 16'h4300};
        wait_flag("done", 400);
        tick(3);
        n_cmp++; if (log_edge.size() != 4) begin n_bad++; $display("FAIL full_count: got %0d want 4", log_edge.size()); end
        if (log_edge.size() == 4 && resp_edge.size() == 4) begin
            n_cmp++; if (log_edge[1] != resp_edge[0] + RST_DLY + 1)
                begin n_bad++; $display("FAIL full_settle: got %0d want %0d", log_edge[1], resp_edge[0] + RST_DLY + 1); end
            for (int i = 2; i < 4; i++) begin
                n_cmp++; if (log_edge[i] != resp_edge[i-1] + 1)
                    begin n_bad++; $display("FAIL full_gap%0d: got %0d want %0d", i, log_edge[i], resp_edge[i-1] + 1); end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (log_addr[i] !== ea[i])
                    begin n_bad++; $display("FAIL full_addr%0d: got %h want %h", i, log_addr[i], ea[i]); end
            end
            n_cmp++; if (done_edge != resp_edge[3])
                begin n_bad++; $display("FAIL full_done_edge: got %0d want %0d", done_edge, resp_edge[3]); end
        end
        n_cmp++; if (log_data.size() < 4 || log_data[3] !== 8'h61)
            begin n_bad++; $display("FAIL full_data3: got %h want 61", wr_data); end
        n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL full_req_idle: got %b want 0", wr_req); end
        n_cmp++; if (tbl_idx !== 8'd3) begin n_bad++; $display("FAIL full_idx: got %0d want 3", tbl_idx); end
    endtask

    task automatic test_nack_retry;
        int k, cnt;
        nack_plan = '{0, 0, 1, 1, 0, 0};
        restart(k);
        wait_flag("done", 600);
        tick(3);
        cnt = 0;
        foreach (log_addr[i]) if (log_addr[i] == 16'h3017 && log_data[i] == 8'hFF) cnt++;
        n_cmp++; if (cnt != 3) begin n_bad++; $display("FAIL retry_reissue: got %0d want 3", cnt); end
        n_cmp++; if (log_edge.size() != 6) begin n_bad++; $display("FAIL retry_count: got %0d want 6", log_edge.size()); end
        n_cmp++; if (log_edge.size() == 6 && log_edge[3] != resp_edge[2] + 1)
            begin n_bad++; $display("FAIL retry_gap: got %0d want %0d", log_edge[3], resp_edge[2] + 1); end
        n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL retry_done: got %b want 1", cfg_done); end
        n_cmp++; if (cfg_err !== 1'b0)  begin n_bad++; $display("FAIL retry_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_nack_err;
        int k;
        nack_plan = '{0, 1, 2, 1};
        restart(k);
        wait_flag("err", 600);
        tick(10);
        n_cmp++; if (resp_edge.size() != 4 || err_edge != resp_edge[3])
            begin n_bad++; $display("FAIL err_edge: got %0d want third nack edge", err_edge); end
        n_cmp++; if (log_edge.size() != 4) begin n_bad++; $display("FAIL err_count: got %0d want 4", log_edge.size()); end
        n_cmp++; if (wr_req !== 1'b0)   begin n_bad++; $display("FAIL err_req: got %b want 0", wr_req); end
        n_cmp++; if (tbl_idx !== 8'd1)  begin n_bad++; $display("FAIL err_idx: got %0d want 1", tbl_idx); end
        n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL err_done: got %b want 0", cfg_done); end
        n_cmp++; if (cfg_err !== 1'b1)  begin n_bad++; $display("FAIL err_flag: got %b want 1", cfg_err); end
    endtask

    task automatic test_drop_in_delay;
        int k, t, nlog;
        nack_plan.delete();
        restart(k);
        t = 0;
        while (resp_edge.size() == 0 && t < 100) begin tick(1); t++; end
        tick(5);
        power_done = 1'b0;
        tick(1);
        n_cmp++; if (wr_req !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0 || tbl_idx !== 8'd0)
            begin n_bad++; $display("FAIL drop_clear: got req=%b done=%b err=%b idx=%0d want all 0", wr_req, cfg_done, cfg_err, tbl_idx); end
        nlog = log_edge.size();
        tick(30);
        n_cmp++; if (log_edge.size() != nlog)
            begin n_bad++; $display("FAIL drop_idle: got %0d writes want %0d", log_edge.size(), nlog); end
        power_done = 1'b1;
        k = cyc + 1;
        t = 0;
        while (log_edge.size() == nlog && t < 100) begin tick(1); t++; end
        n_cmp++; if (log_edge.size() <= nlog || log_edge[nlog] != k + START_DLY + 1)
            begin n_bad++; $display("FAIL drop_restart_edge: got %0d want %0d", (log_edge.size() > nlog) ? log_edge[nlog] : -1, k + START_DLY + 1); end
        n_cmp++; if (log_addr.size() <= nlog || log_addr[nlog] !== 16'h3008)
            begin n_bad++; $display("FAIL drop_restart_addr: got %h want 3008", wr_addr); end
        wait_flag("done", 400);
    endtask

    initial begin
        int k;
        test_reset;
        test_first_req(k);
        test_full_run;
        test_nack_retry;
        test_nack_err;
        test_drop_in_delay;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ov5640_cfg_ctrl.md
# ov5640_cfg_ctrl

Sequences OV5640 register configuration once the camera power-up sequence has finished. Waits for `power_done` from the power controller, then walks an external register table (ROM) entry by entry and issues each 16-bit-address/8-bit-data write to the SCCB write master through a request/acknowledge handshake. Handles the post-soft-reset settle delay and bounded NACK retries, then flags `cfg_done` (or `cfg_err`) to the capture path.

## Interface
- `REG_NUM`, 252: number of table entries; indices 0..REG_NUM-1.
- `IDX_W`, 8: width of `tbl_idx`; must satisfy 2^IDX_W >= REG_NUM.
- `START_DLY`, 20000: sclk cycles from `power_done` to the first table fetch.
- `RST_DLY`, 50000: settle cycles after a soft-reset write (addr 0x3008, data bit7 = 1).
- `MAX_RETRY`, 3: NACKs tolerated per entry before error.
- `sclk` in 1: system clock; all logic rises on it.
- `s_rst_n` in 1: asynchronous active-low reset.
- `power_done` in 1: level, high once the power sequence is complete.
- `tbl_idx` out IDX_W: table read index.
- `tbl_data` in 24: {reg_addr[15:0], reg_data[7:0]}; valid one cycle after `tbl_idx` changes.
- `wr_req` out 1: write request to the SCCB master.
- `wr_addr` out 16: register address; stable while `wr_req` is high.
- `wr_data` out 8: register data; stable while `wr_req` is high.
- `wr_ack` in 1: one-cycle pulse, write acknowledged by the sensor.
- `wr_nack` in 1: one-cycle pulse, write NACKed.
- `cfg_done` out 1: level, all entries written.
- `cfg_err` out 1: level, retry limit exceeded.

## Operation
- States: IDLE, WAIT, FETCH, REQ, DELAY, DONE, ERR.
- IDLE: delay counter, `tbl_idx` and retry counter are 0. `power_done` = 1 moves to WAIT.
- WAIT: counter counts 0..START_DLY-1. At START_DLY-1 it clears and the state moves to FETCH.
- FETCH: one cycle with `tbl_idx` stable, then REQ.
- Entering REQ: `wr_addr`/`wr_data` load from `tbl_data` and `wr_req` goes to 1.
- REQ: `wr_req` holds until `wr_ack` or `wr_nack`.
- `wr_ack`: retry counter clears.
  - Latched entry is a soft reset (`wr_addr` = 0x3008 and `wr_data[7]` = 1): go to DELAY.
  - Otherwise, `tbl_idx` = REG_NUM-1: go to DONE.
  - Otherwise: `tbl_idx` += 1 and go to FETCH.
- DELAY: counts RST_DLY cycles, then advances exactly as the ack-without-soft-reset case.
- `wr_nack`: retry counter += 1.
  - New value = MAX_RETRY: go to ERR.
  - Otherwise: go to FETCH with the same `tbl_idx`, which re-issues the entry.
- `wr_ack` and `wr_nack` in the same cycle: treated as a NACK.
- `wr_ack`/`wr_nack` outside REQ: ignored.
- DONE holds `cfg_done` = 1; ERR holds `cfg_err` = 1. Both are terminal while `power_done` = 1.
- `power_done` = 0 in any state: next cycle is IDLE.
  - `wr_req`, `cfg_done`, `cfg_err` clear; counters and `tbl_idx` clear.
  - A later rise restarts from entry 0.
- Counter widths: wide enough for max(START_DLY, RST_DLY); no wrap is reachable.

## Timing
- Reset values: `tbl_idx` = 0, `wr_req` = 0, `wr_addr` = 0x0000, `wr_data` = 0x00, `cfg_done` = 0, `cfg_err` = 0; state IDLE.
- `power_done` sampled high at edge k:
  - WAIT from edge k.
  - FETCH at edge k+START_DLY.
  - `wr_req` high from edge k+START_DLY+1.
- `wr_ack` sampled at edge a:
  - `wr_req` low from edge a.
  - Next entry: FETCH at edge a, `wr_req` high again at edge a+1.
  - Soft-reset entry: FETCH at edge a+RST_DLY, `wr_req` high at edge a+RST_DLY+1.
- `wr_nack` at edge n (retry): `wr_req` low at edge n, high again at edge n+1 with the same address and data.
- `cfg_done` high from the edge sampling the final `wr_ack`; `cfg_err` high from the edge sampling the final `wr_nack`.
- All outputs are registered.

## Test plan
Bench parameters: REG_NUM=4, START_DLY=10, RST_DLY=20, MAX_RETRY=3. Table: {0x3008,0x82}, {0x3103,0x11}, {0x3017,0xFF}, {0x4300,0x61}. Ack model: `wr_ack` 5 cycles after `wr_req` rises.
- Release reset, `power_done` held 0 for 50 cycles -> all outputs at reset values, `tbl_idx` = 0.
- `power_done` rises -> first `wr_req` exactly 11 cycles after it is sampled; addr/data 0x3008/0x82.
- Full run -> 20-cycle gap after the 0x3008 ack before entry 1; entries 1..3 each 1 cycle after the previous ack; `cfg_done` = 1 on the 4th ack; exactly 4 writes logged.
- NACK entry 2 twice then ACK -> 0x3017/0xFF issued 3 times; `cfg_done` still set; `cfg_err` = 0.
- NACK entry 1 three times -> `cfg_err` = 1 on the 3rd NACK; `wr_req` stays 0; `tbl_idx` = 1.
- `power_done` dropped during DELAY, raised again -> IDLE next cycle; outputs cleared; sequence restarts at entry 0 with START_DLY timing.
